ev_controller: RTL and testbench
================================

EV_CONTROLLER -- requirements
Module: ev_controller

Interface
REQ-001 The block SHALL have parameter FILL_CYCLES, default 8, legal range 1..15: clock cycles of valve flow to move the chamber between outer and inner level.
REQ-002 The block SHALL have port Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port SwitchFlip  input  1  operator valve switch level; each toggle is one request.
REQ-005 The block SHALL have port OCClosed  input  1  1 = outer port fully closed.
REQ-006 The block SHALL have port ICClosed  input  1  1 = inner port fully closed.
REQ-007 The block SHALL have port EVState  output  1  1 = chamber equalized with the outer side, so the outer port may operate.
REQ-008 The block SHALL have port IVState  output  1  1 = chamber equalized with the inner side.
REQ-009 The block SHALL have port ValveOpen  output  1  1 = equalization valve flowing this cycle.
REQ-010 The block SHALL have port Level  output  4  chamber level: 0 = outer level, FILL_CYCLES = inner level.

Function
REQ-011 The block SHALL register SwitchFlip into SwitchPrev every cycle; a request exists in a cycle when SwitchFlip differs from SwitchPrev (either edge).
REQ-012 The block SHALL implement states AT_OUTER, FILLING, AT_INNER and DRAINING in one registered state machine.
REQ-013 The block SHALL decode EVState as state==AT_OUTER and IVState as state==AT_INNER, both taken from the state register.
REQ-014 The block SHALL decode ValveOpen combinationally as (FILLING or DRAINING) AND OCClosed AND ICClosed.
REQ-015 In AT_OUTER, a request with OCClosed=ICClosed=1 SHALL move the state to FILLING at that edge.
REQ-016 In AT_INNER, a request with OCClosed=ICClosed=1 SHALL move the state to DRAINING at that edge.
REQ-017 In AT_OUTER or AT_INNER, a request with either port open SHALL be dropped, not queued; state and Level are held.
REQ-018 In FILLING with ValveOpen=1 and no request, Level SHALL increment by 1 per edge.
REQ-019 FILLING SHALL move to AT_INNER on the same edge that Level becomes FILL_CYCLES.
REQ-020 In DRAINING with ValveOpen=1 and no request, Level SHALL decrement by 1 per edge.
REQ-021 DRAINING SHALL move to AT_OUTER on the same edge that Level becomes 0.
REQ-022 In FILLING or DRAINING with either port open, Level and state SHALL hold (pause); flow resumes on the first edge with both ports closed.
REQ-023 A request in FILLING SHALL switch the state to DRAINING, and a request in DRAINING SHALL switch it to FILLING, regardless of port status; Level is not changed on that edge.
REQ-024 When a request coincides with the edge that would complete the move, the reversal SHALL take priority: no completion, and Level is held.
REQ-025 Level SHALL never exceed FILL_CYCLES or go below 0; it SHALL saturate with no wrap-around.
REQ-026 Latency: the fill SHALL start on the request edge k; Level SHALL read 1 after edge k+1; IVState SHALL read 1 after edge k+FILL_CYCLES when there is no pause.

Reset
REQ-027 Reset=0 SHALL immediately force state=AT_OUTER, Level=0 and SwitchPrev=0, independent of Clock.
REQ-028 During reset, outputs SHALL read EVState=1, IVState=0, ValveOpen=0.
REQ-029 Reset asserted mid-FILLING or mid-DRAINING SHALL abandon the move with no completion pulse.
REQ-030 After release, a SwitchFlip held at 1 SHALL count as one request on the first edge.

Verification
REQ-031 The bench SHALL cover basic fill: reset, ports closed, SwitchFlip 0->1 at edge k -> EVState=0 after edge k, Level steps 1..8, IVState=1 after edge k+8, ValveOpen=0 afterwards.
REQ-032 The bench SHALL cover a blocked request: AT_OUTER with OCClosed=0, toggle SwitchFlip -> no state change, EVState stays 1; closing OCClosed later does not start a fill.
REQ-033 The bench SHALL cover pause: FILLING at Level=3, ICClosed=0 for 4 cycles -> Level holds 3 and ValveOpen=0; on reclose, Level continues to 4 on the next edge.
REQ-034 The bench SHALL cover reversal: FILLING at Level=5, SwitchFlip toggles -> DRAINING with Level held at 5, then 4..0, EVState=1 when Level=0.
REQ-035 The bench SHALL cover simultaneous events: request on the edge where Level 7 would become 8 -> state DRAINING, Level stays 7, IVState never asserts.
REQ-036 The bench SHALL cover async reset mid-drain: Reset=0 between edges at Level=4 -> Level=0 and EVState=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ev_controller.sv
// Equalization-valve controller for a two-port chamber: a switch toggle starts,
// reverses or is refused depending on port status, and Level tracks the fill.
module ev_controller #(
    parameter int unsigned FILL_CYCLES = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SwitchFlip,
    input  logic       OCClosed,
    input  logic       ICClosed,
    output logic       EVState,
    output logic       IVState,
    output logic       ValveOpen,
    output logic [3:0] Level
);

    typedef enum logic [1:0] {
        AT_OUTER = 2'd0,
        FILLING  = 2'd1,
        AT_INNER = 2'd2,
        DRAINING = 2'd3
    } state_t;

    localparam logic [3:0] FILL_LVL = 4'(FILL_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] level_q, level_d;
    logic       switch_prev_q;
    logic       req_s;
    logic       both_closed_s;

    assign req_s         = SwitchFlip ^ switch_prev_q;
    assign both_closed_s = OCClosed & ICClosed;

    // Next-state and level; a request while moving reverses the move and beats completion
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            AT_OUTER: begin
                if (req_s && both_closed_s) begin
                    state_d = FILLING;
                end else begin
                    state_d = AT_OUTER;
                end
            end
            FILLING: begin
                if (req_s) begin
                    state_d = DRAINING;
                end else if (both_closed_s) begin
                    // Also covers a reversal that left Level already at the top
                    if (level_q >= (FILL_LVL - 4'd1)) begin
                        level_d = FILL_LVL;
                        state_d = AT_INNER;
                    end else begin
                        level_d = level_q + 4'd1;
                    end
                end else begin
                    state_d = FILLING;
                end
            end
            AT_INNER: begin
                if (req_s && both_closed_s) begin
                    state_d = DRAINING;
                end else begin
                    state_d = AT_INNER;
                end
            end
            DRAINING: begin
                if (req_s) begin
                    state_d = FILLING;
                end else if (both_closed_s) begin
                    if (level_q <= 4'd1) begin
                        level_d = 4'd0;
                        state_d = AT_OUTER;
                    end else begin
                        level_d = level_q - 4'd1;
                    end
                end else begin
                    state_d = DRAINING;
                end
            end
            default: begin
                state_d = AT_OUTER;
                level_d = 4'd0;
            end
        endcase
    end

    // State, level and switch history registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= AT_OUTER;
            level_q       <= 4'd0;
            switch_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            switch_prev_q <= SwitchFlip;
        end
    end

    assign EVState   = (state_q == AT_OUTER);
    assign IVState   = (state_q == AT_INNER);
    assign ValveOpen = ((state_q == FILLING) || (state_q == DRAINING)) && both_closed_s;
    assign Level     = level_q;

endmodule

// File: tb/tb_ev_controller.sv
// Table-driven bench for ev_controller with a scoreboard queue of expected outputs.
module tb_ev_controller;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       SwitchFlip;
    logic       OCClosed;
    logic       ICClosed;
    logic       EVState;
    logic       IVState;
    logic       ValveOpen;
    logic [3:0] Level;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic       sw;
        logic       oc;
        logic       ic;
        logic       ev;
        logic       iv;
        logic       vo;
        logic [3:0] lvl;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    ev_controller #(.FILL_CYCLES(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .SwitchFlip(SwitchFlip),
        .OCClosed  (OCClosed),
        .ICClosed  (ICClosed),
        .EVState   (EVState),
        .IVState   (IVState),
        .ValveOpen (ValveOpen),
        .Level     (Level)
    );

    always #5 Clock = ~Clock;

    function automatic void add(input logic sw, input logic oc, input logic ic,
                                input logic ev, input logic iv, input logic vo,
                                input logic [3:0] lvl);
        vec_t v;
        v.sw = sw; v.oc = oc; v.ic = ic;
        v.ev = ev; v.iv = iv; v.vo = vo; v.lvl = lvl;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outputs(input int idx, input vec_t e);
        chk("EVState",   idx, {3'd0, EVState},   {3'd0, e.ev});
        chk("IVState",   idx, {3'd0, IVState},   {3'd0, e.iv});
        chk("ValveOpen", idx, {3'd0, ValveOpen}, {3'd0, e.vo});
        chk("Level",     idx, Level,             e.lvl);
    endtask

    // Drive one vector at the falling edge, compare just after the next rising edge
    task automatic apply(input int idx);
        vec_t e;
        SwitchFlip = tbl[idx].sw;
        OCClosed   = tbl[idx].oc;
        ICClosed   = tbl[idx].ic;
        sb.push_back(tbl[idx]);
        @(posedge Clock);
        #1;
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL scoreboard_empty vec=%0d got=0 expected=1", idx);
        end else begin
            e = sb.pop_front();
            chk_outputs(idx, e);
        end
        @(negedge Clock);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            apply(i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t rst_exp;
        int   end_d;

        // Basic fill to the inner level, then reversal straight after leaving it
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
        for (int i = 7; i >= 1; i--) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Blocked request is dropped, not queued
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Pause at Level 3, resume, reverse at 5 and drain home
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 1; i <= 3; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        for (int i = 4; i >= 1; i--) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Request on the completing edge: reversal wins, Level held at 7
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
        for (int i = 6; i >= 4; i--) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        end_d = tbl.size();
        // After reset release with switch held high, plus reversal with a port open
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        rst_exp.sw = 1'b0; rst_exp.oc = 1'b1; rst_exp.ic = 1'b1;
        rst_exp.ev = 1'b1; rst_exp.iv = 1'b0; rst_exp.vo = 1'b0; rst_exp.lvl = 4'd0;

        Reset      = 1'b0;
        SwitchFlip = 1'b0;
        OCClosed   = 1'b1;
        ICClosed   = 1'b1;
        #1;
        chk_outputs(-1, rst_exp);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        run(0, end_d);

        // Async reset between edges at Level 4 while draining
        Reset = 1'b0;
        #1;
        chk_outputs(-2, rst_exp);
        SwitchFlip = 1'b1;
        @(posedge Clock);
        #1;
        chk_outputs(-3, rst_exp);
        @(negedge Clock);
        Reset = 1'b1;

        run(end_d, tbl.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
